cascade_cnt: RTL and testbench
==============================

# cascade_cnt

Second-stage event counter fed by the wrap tick of the upstream modulo prescaler (mod-6 `up_cnt`, wrap at 5→0). It counts prescaler wraps up to a programmable limit and emits a one-cycle terminal-count pulse. It runs periodic or one-shot under a small start/stop state machine. It sits directly downstream of the prescaler and forms the slow time base for flag logic.

## Interface
- `WIDTH`, 4: width of the count and limit.
- `CLK` input 1: clock; all state updates on the rising edge.
- `RST` input 1: synchronous, active-high reset.
- `TICK` input 1: upstream prescaler wrap strobe, one cycle wide.
- `START` input 1: start/restart request; latches `LIMIT` and `ONESHOT`.
- `STOP` input 1: abort request.
- `LIMIT` input `WIDTH`: terminal count value, sampled only at an accepted `START`.
- `ONESHOT` input 1: 1 means stop after the first terminal count; sampled only at an accepted `START`.
- `TC_ACK` input 1: acknowledges a pending terminal count. Used only with `CASCADE_CNT_OVF_EN`.
- `CNT` output `WIDTH`: current count.
- `TC` output 1: one-cycle terminal-count pulse.
- `BUSY` output 1: high in RUN.
- `DONE` output 1: one-cycle pulse on one-shot completion.
- `OVF` output 1: sticky missed-acknowledge flag. Used only with `CASCADE_CNT_OVF_EN`.

## Operation
- States are IDLE, RUN and FIN. Reset enters IDLE.
- IDLE:
  - `START`=1 and `STOP`=0: go to RUN, `CNT`<=0, latch `LIMIT` and `ONESHOT`.
  - `TICK` is ignored.
- RUN, with priority STOP > START > TICK:
  - `STOP`: go to IDLE, `CNT`<=0, no `TC`.
  - `START`: restart. `CNT`<=0, relatch `LIMIT` and `ONESHOT`, stay in RUN. A `TICK` in the same cycle is ignored.
  - `TICK` with `CNT` != latched limit: `CNT`<=`CNT`+1.
  - `TICK` with `CNT` == latched limit:
    - `CNT`<=0 and `TC`<=1.
    - If the latched `ONESHOT`=1, go to FIN; otherwise stay in RUN.
- FIN lasts exactly one cycle. `DONE`=1 and `BUSY`=0, then go to IDLE unconditionally. Inputs are ignored in FIN.
- Arithmetic:
  - The limit compare is unsigned and full-width.
  - Latched limit 0 gives `TC` on every `TICK`.
  - Limit L gives period (L+1) ticks.
  - `CNT` never exceeds the latched limit, so no natural wrap occurs.
- `LIMIT` and `ONESHOT` changes outside an accepted `START` have no effect.

## Timing
- All outputs are registered. Reset values: `CNT`=0, `TC`=0, `BUSY`=0, `DONE`=0, `OVF`=0, state IDLE.
- `RST` overrides every other input in the same cycle, including mid-count.
- Accepted `START` at edge N:
  - `BUSY`=1 and `CNT`=0 after edge N.
  - The first countable `TICK` is the one sampled at edge N+1.
- Terminal `TICK` sampled at edge N: `TC`=1 for the cycle after edge N only, with `CNT`=0 in that same cycle.
- One-shot: `TC` and `DONE` are asserted in the same cycle (after the terminal edge). `BUSY` drops in that same cycle.
- A `START` in the FIN cycle is dropped; the bench must reissue it.
- Back-to-back `TICK`s (every cycle) are legal, each counts.

## Configuration
- `CASCADE_CNT_OVF_EN` defined:
  - A pending flag sets on each `TC` and clears on `TC_ACK`=1.
  - If `TC` fires while the flag is still pending and `TC_ACK` is 0 in that cycle, `OVF`<=1.
  - `TC_ACK` coincident with a new `TC` clears the old pending event, keeps the new one pending, and sets no `OVF`.
  - `OVF` is sticky and clears only on `RST` or an accepted `START`.
- `CASCADE_CNT_OVF_EN` undefined: no pending flag, `OVF` is tied 0, `TC_ACK` is ignored. Ports are present in both builds.

## Test plan
- Reset mid-count: `LIMIT`=3, START, 2 ticks (`CNT`=2), assert `RST` -> next cycle all outputs 0, state IDLE; later `TICK`s leave `CNT`=0.
- Periodic: `LIMIT`=2, `ONESHOT`=0, `TICK` every 6th cycle -> `CNT` 0,1,2,0,…; `TC` one cycle wide every 18 cycles; `BUSY` stays 1.
- One-shot: `LIMIT`=1, `ONESHOT`=1, START, 2 ticks -> after the second tick `TC`=1, `DONE`=1, `BUSY`=0 in the same cycle; IDLE next cycle; further ticks leave `CNT`=0.
- Priority: in RUN with `CNT`=limit, `STOP`+`TICK` together -> no `TC`, `CNT`=0, IDLE. `START`+`TICK` together -> `CNT`=0, no `TC`, new `LIMIT` latched.
- Limit 0 and back-to-back: `LIMIT`=0, `TICK` held high 4 cycles -> `TC` high 4 consecutive cycles, `CNT` stays 0.
- `CASCADE_CNT_OVF_EN`: `LIMIT`=0, two `TC`s with no `TC_ACK` -> `OVF`=1 and stays 1; repeat with `TC_ACK` after each `TC` -> `OVF`=0; a START clears `OVF`.

Source files
------------

// File: rtl/cascade_cnt.sv
// Second-stage event counter: counts prescaler wrap ticks up to a latched limit, pulses TC.
// Optional missed-acknowledge tracking is enabled by defining CASCADE_CNT_OVF_EN.
module cascade_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             TICK,
    input  logic             START,
    input  logic             STOP,
    input  logic [WIDTH-1:0] LIMIT,
    input  logic             ONESHOT,
    input  logic             TC_ACK,
    output logic [WIDTH-1:0] CNT,
    output logic             TC,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVF
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             one_q, one_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_acc;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lim_d     = lim_q;
        one_d     = one_q;
        tc_d      = 1'b0;
        done_d    = 1'b0;
        start_acc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (START && !STOP) begin
                    state_d   = StRun;
                    cnt_d     = '0;
                    lim_d     = LIMIT;
                    one_d     = ONESHOT;
                    start_acc = 1'b1;
                end
            end
            StRun: begin
                if (STOP) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (START) begin
                    cnt_d     = '0;
                    lim_d     = LIMIT;
                    one_d     = ONESHOT;
                    start_acc = 1'b1;
                end else if (TICK) begin
                    if (cnt_q == lim_q) begin
                        cnt_d = '0;
                        tc_d  = 1'b1;
                        if (one_q) begin
                            state_d = StFin;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StRun);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            lim_q   <= '0;
            one_q   <= 1'b0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            one_q   <= one_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef CASCADE_CNT_OVF_EN
    logic pend_q, pend_d;
    logic ovf_q, ovf_d;

    // An ack coincident with a new TC retires the old event; the new one stays pending.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (tc_d) begin
            pend_d = 1'b1;
        end else if (TC_ACK) begin
            pend_d = 1'b0;
        end
        if (start_acc) begin
            ovf_d = 1'b0;
        end else if (tc_d && pend_q && !TC_ACK) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`else
    logic unused_ovf_inputs;
    assign unused_ovf_inputs = TC_ACK ^ start_acc;
    assign OVF = 1'b0;
`endif

    assign CNT  = cnt_q;
    assign TC   = tc_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_cascade_cnt.sv
// Directed self-checking bench for cascade_cnt; OVF expectations follow CASCADE_CNT_OVF_EN.
module tb_cascade_cnt;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       TICK = 1'b0;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic [3:0] LIMIT = 4'd0;
    logic       ONESHOT = 1'b0;
    logic       TC_ACK = 1'b0;
    logic [3:0] CNT;
    logic       TC;
    logic       BUSY;
    logic       DONE;
    logic       OVF;

    int checks = 0;
    int failures = 0;
    logic ovf_en;

    cascade_cnt #(.WIDTH(4)) dut (
        .CLK(CLK), .RST(RST), .TICK(TICK), .START(START), .STOP(STOP),
        .LIMIT(LIMIT), .ONESHOT(ONESHOT), .TC_ACK(TC_ACK),
        .CNT(CNT), .TC(TC), .BUSY(BUSY), .DONE(DONE), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of strobes, sample 1 time unit after the edge.
    task automatic cyc(input logic tick, input logic start, input logic stop);
        TICK = tick;
        START = start;
        STOP = stop;
        @(posedge CLK);
        #1;
        TICK = 1'b0;
        START = 1'b0;
        STOP = 1'b0;
    endtask

    initial begin
`ifdef CASCADE_CNT_OVF_EN
        ovf_en = 1'b1;
`else
        ovf_en = 1'b0;
`endif
        // Reset state
        RST = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        chk("rst_cnt", CNT, 0);
        chk("rst_tc", TC, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_ovf", OVF, 0);

        // Reset mid-count
        LIMIT = 4'd3;
        cyc(1'b0, 1'b1, 1'b0);
        chk("mid_start_busy", BUSY, 1);
        chk("mid_start_cnt", CNT, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("mid_cnt1", CNT, 1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("mid_cnt2", CNT, 2);
        RST = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        RST = 1'b0;
        chk("mid_rst_cnt", CNT, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_tc", TC, 0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("mid_idle_cnt", CNT, 0);
        chk("mid_idle_busy", BUSY, 0);

        // Periodic, limit 2, tick every 6th cycle
        LIMIT = 4'd2;
        ONESHOT = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 9; k++) begin
            for (int j = 0; j < 5; j++) begin
                cyc(1'b0, 1'b0, 1'b0);
                chk("per_gap_tc", TC, 0);
                chk("per_gap_cnt", CNT, k % 3);
            end
            cyc(1'b1, 1'b0, 1'b0);
            chk("per_cnt", CNT, (k + 1) % 3);
            chk("per_tc", TC, ((k + 1) % 3 == 0) ? 1 : 0);
            chk("per_busy", BUSY, 1);
        end

        // One-shot, limit 1; START in FIN is dropped
        LIMIT = 4'd1;
        ONESHOT = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        chk("os_start_cnt", CNT, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("os_cnt1", CNT, 1);
        chk("os_tc0", TC, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("os_tc", TC, 1);
        chk("os_done", DONE, 1);
        chk("os_busy", BUSY, 0);
        chk("os_cnt0", CNT, 0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("os_fin_done", DONE, 0);
        chk("os_fin_tc", TC, 0);
        chk("os_fin_busy", BUSY, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("os_idle_cnt", CNT, 0);
        chk("os_idle_busy", BUSY, 0);

        // Priority: STOP beats TICK at limit
        ONESHOT = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("pri_at_lim", CNT, 1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("pri_stop_tc", TC, 0);
        chk("pri_stop_cnt", CNT, 0);
        chk("pri_stop_busy", BUSY, 0);
        // START beats TICK at limit and relatches LIMIT
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        LIMIT = 4'd3;
        cyc(1'b1, 1'b1, 1'b0);
        chk("pri_start_tc", TC, 0);
        chk("pri_start_cnt", CNT, 0);
        chk("pri_start_busy", BUSY, 1);
        LIMIT = 4'd0;
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("pri_new_cnt", CNT, i);
            chk("pri_new_tc", TC, 0);
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("pri_new_wrap_tc", TC, 1);
        chk("pri_new_wrap_cnt", CNT, 0);

        // Limit 0, back-to-back ticks
        TC_ACK = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        TC_ACK = 1'b0;
        chk("l0_start_ovf", OVF, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("l0_tc", TC, 1);
            chk("l0_cnt", CNT, 0);
            chk("l0_ovf", OVF, (ovf_en && i >= 1) ? 1 : 0);
        end
        cyc(1'b0, 1'b0, 1'b0);
        chk("l0_tc_end", TC, 0);
        chk("l0_ovf_sticky", OVF, ovf_en ? 1 : 0);

        // Acknowledged TCs never raise OVF; START clears it
        TC_ACK = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        TC_ACK = 1'b0;
        chk("ack_start_ovf", OVF, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("ack_tc1", TC, 1);
        chk("ack_ovf1", OVF, 0);
        TC_ACK = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        chk("ack_coinc_tc", TC, 1);
        chk("ack_coinc_ovf", OVF, 0);
        cyc(1'b0, 1'b0, 1'b0);
        TC_ACK = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        chk("ack_tc3", TC, 1);
        chk("ack_ovf3", OVF, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
